// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: IF/ID/EX/MEM/WB sequencer with memory handshake, traps and retire counter
module multicycle_control_unit #(
  parameter int CNT_W = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             jump,
  output logic             beq,
  output logic             bne,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [1:0]       alu_op,
  output logic             illegal_instr,
  output logic             bus_error,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);
  localparam int WW = MEM_TIMEOUT < 2 ? 1 : $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP} state_t;
  state_t state, nxt;
  logic [3:0] ir_op;
  logic [WW-1:0] wcnt;
  logic lw, sw, rt, bq, bn, jp, ill, act, timeout;
  assign lw = ir_op == 4'd0;
  assign sw = ir_op == 4'd1;
  assign rt = ir_op inside {[4'd2:4'd9]};
  assign bq = ir_op == 4'd11;
  assign bn = ir_op == 4'd12;
  assign jp = ir_op == 4'd13;
  assign ill = !(lw | sw | rt | bq | bn | jp);
  assign act = state inside {S_ID, S_EX, S_MEM, S_WB};
  assign timeout = MEM_TIMEOUT != 0 && !mem_ready && wcnt + 1'b1 == WW'(MEM_TIMEOUT);
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IF;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_IF:   nxt = S_ID;
      S_ID:   nxt = ill ? S_TRAP : S_EX;
      S_EX:   nxt = rt ? S_WB : (lw | sw) ? S_MEM : S_IF;
      S_MEM:  nxt = mem_ready ? (lw ? S_WB : S_IF) : timeout ? S_TRAP : S_MEM;
      S_WB:   nxt = S_IF;
      S_TRAP: nxt = S_TRAP;
      default: nxt = S_IF;
    endcase
  end
  always_comb begin
    alu_src    = act & (lw | sw);
    mem_to_reg = act & lw;
    reg_dst    = act & rt;
    alu_op     = !act ? 2'b00 : (lw | sw) ? 2'b10 : (bq | bn) ? 2'b01 : 2'b00;
    jump       = state == S_EX && jp;
    beq        = state == S_EX && bq;
    bne        = state == S_EX && bn;
    mem_read   = state == S_MEM && lw;
    mem_write  = state == S_MEM && sw;
    reg_write  = state == S_WB;
    pc_write   = (state == S_EX && (bq | bn | jp)) || (state == S_MEM && sw && mem_ready) || state == S_WB;
    halted     = state == S_TRAP;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ir_op         <= '0;
      wcnt          <= '0;
      instr_count   <= '0;
      illegal_instr <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      ir_op         <= state == S_IF ? opcode : ir_op;
      wcnt          <= state == S_EX ? '0 : (state == S_MEM && !mem_ready) ? wcnt + 1'b1 : wcnt;
      instr_count   <= instr_count + CNT_W'(pc_write);
      illegal_instr <= illegal_instr | (state == S_ID && ill);
      bus_error     <= bus_error | (state == S_MEM && timeout);
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: instruction-level schedule model checked every cycle, plus literal checks
module tb_multicycle_control_unit;
  localparam int CW = 4;
  localparam int T = 15;
  localparam int PCW = 14, JMP = 13, BEQ = 12, BNE = 11, MRD = 10, MWR = 9;
  localparam int ASRC = 8, RDST = 7, M2R = 6, RW = 5, ILL = 2, BUS = 1, HLT = 0;
  logic clk = 0, reset = 1, mem_ready = 0;
  logic [3:0] opcode = 0;
  logic pc_write, jump, beq, bne, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write;
  logic illegal_instr, bus_error, halted;
  logic [1:0] alu_op;
  logic [CW-1:0] instr_count;
  logic [14:0] exp_v = 0, dut_v;
  logic [CW-1:0] exp_cnt = 0;
  logic exp_ill = 0, exp_bus = 0;
  int budget = -1, total = 0, passed = 0;
  multicycle_control_unit #(.CNT_W(CW), .MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .jump(jump), .beq(beq), .bne(bne),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_op(alu_op), .illegal_instr(illegal_instr), .bus_error(bus_error),
    .halted(halted), .instr_count(instr_count));
  always #5 clk = ~clk;
  assign dut_v = {pc_write, jump, beq, bne, mem_read, mem_write, alu_src, reg_dst,
                  mem_to_reg, reg_write, alu_op, illegal_instr, bus_error, halted};
  always @(negedge clk) begin
    total++;
    if (dut_v === exp_v) passed++;
    else $display("FAIL outputs t=%0t: got %b want %b", $time, dut_v, exp_v);
    total++;
    if (instr_count === exp_cnt) passed++;
    else $display("FAIL instr_count t=%0t: got %0d want %0d", $time, instr_count, exp_cnt);
    if (exp_v[PCW]) exp_cnt = exp_cnt + 1'b1;
  end
  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d want %0d", nm, got, want);
  endtask
  task automatic cyc(input logic [14:0] e, input logic rdy, input logic [3:0] op);
    if (budget == 0) return;
    if (budget > 0) budget--;
    opcode = op;
    mem_ready = rdy;
    e[ILL] = exp_ill;
    e[BUS] = exp_bus;
    exp_v = e;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1;
    mem_ready = 0;
    exp_v = 0;
    exp_ill = 0;
    exp_bus = 0;
    exp_cnt = 0;
    @(posedge clk);
    #1;
    reset = 0;
  endtask
  task automatic trap(input int n);
    logic [14:0] h;
    h = 0;
    h[HLT] = 1;
    for (int i = 0; i < n; i++) cyc(h, i[0], 4'h2);
  endtask
  // opcode is only honoured in IF, so every later cycle drives its complement
  task automatic exec(input logic [3:0] op, input int waits);
    logic [14:0] s, b, m;
    logic lw, sw, rt, br;
    int n;
    lw = op == 0;
    sw = op == 1;
    rt = op >= 2 && op <= 9;
    br = op == 11 || op == 12 || op == 13;
    s = 0;
    if (lw) begin s[ASRC] = 1; s[M2R] = 1; s[4:3] = 2'b10; end
    if (sw) begin s[ASRC] = 1; s[4:3] = 2'b10; end
    if (rt) s[RDST] = 1;
    if (op == 11 || op == 12) s[4:3] = 2'b01;
    cyc(0, 1, op);
    if (!(lw | sw | rt | br)) begin
      cyc(0, 1, ~op);
      exp_ill = 1;
      return;
    end
    cyc(s, 1, ~op);
    if (br) begin
      b = s;
      b[PCW] = 1;
      b[op == 11 ? BEQ : op == 12 ? BNE : JMP] = 1;
      cyc(b, 1, ~op);
      return;
    end
    cyc(s, 1, ~op);
    if (rt) begin
      b = s;
      b[RW] = 1;
      b[PCW] = 1;
      cyc(b, 1, ~op);
      return;
    end
    n = waits >= T ? T : waits;
    m = s;
    m[lw ? MRD : MWR] = 1;
    for (int i = 0; i < n; i++) cyc(m, 0, ~op);
    if (waits >= T) begin
      if (budget != 0) exp_bus = 1;
      return;
    end
    m[PCW] = sw;
    cyc(m, 1, ~op);
    if (lw) begin
      b = s;
      b[RW] = 1;
      b[PCW] = 1;
      cyc(b, 1, ~op);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    exec(4'd2, 0);
    check("add_count", int'(instr_count), 1);
    exec(4'd0, 2);
    check("lw_count", int'(instr_count), 2);
    exec(4'd1, 0);
    check("sw_count", int'(instr_count), 3);
    do_reset();
    exec(4'd11, 0);
    exec(4'd13, 0);
    check("br_jmp_count", int'(instr_count), 2);
    exec(4'd12, 0);
    exec(4'd9, 3);
    exec(4'd5, 0);
    exec(4'd1, 3);
    exec(4'd0, 14);
    check("mixed_count", int'(instr_count), 7);
    do_reset();
    for (int i = 0; i < 17; i++) exec(4'd13, 0);
    check("wrap_count", int'(instr_count), 1);
    do_reset();
    exec(4'd14, 0);
    trap(20);
    check("ill_halted", int'(halted), 1);
    check("ill_flag", int'(illegal_instr), 1);
    check("ill_no_retire", int'(instr_count), 0);
    do_reset();
    check("ill_cleared", int'(illegal_instr), 0);
    check("halt_cleared", int'(halted), 0);
    exec(4'd10, 0);
    trap(2);
    do_reset();
    exec(4'd15, 0);
    trap(2);
    do_reset();
    exec(4'd0, 100);
    trap(5);
    check("timeout_bus", int'(bus_error), 1);
    check("timeout_halt", int'(halted), 1);
    do_reset();
    exec(4'd1, 15);
    trap(3);
    do_reset();
    exec(4'd3, 0);
    budget = 5;
    exec(4'd0, 10);
    budget = -1;
    check("mid_mem_read", int'(mem_read), 1);
    do_reset();
    check("abort_count", int'(instr_count), 0);
    check("abort_bus", int'(bus_error), 0);
    exec(4'd2, 0);
    check("after_abort_count", int'(instr_count), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
